half_match_frame_arbiter: RTL and testbench

Shares one half-word match datapath between two frame-oriented requester streams. Each accepted 32-bit word is checked: both 16-bit halves equal `MATCH_VAL` (two compare bits concatenated, +1, zero-test). Per frame, the block counts fully matching words and reports one result beat tagged with the source. Frames from the two requesters are arbitrated round-robin at frame granularity and never interleave.

---
 rtl/half_match_frame_arbiter_pkg.sv | 10 +
 rtl/half_match_frame_arbiter_cmp.sv | 13 +
 rtl/half_match_frame_arbiter.sv | 85 ++++++++
 tb/tb_half_match_frame_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/half_match_frame_arbiter_pkg.sv
// half_match_frame_arbiter_pkg: shared FSM states, default parameters and counter saturation limit.
package half_match_frame_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, EMIT} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MATCH_VAL = 1;
  localparam int DEF_CNT_WIDTH = 8;
  function automatic longint unsigned cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/half_match_frame_arbiter_cmp.sv
// half_match_cmp: flags a word whose two halves both equal MATCH_VAL.
module half_match_cmp #(
  parameter int HALF_WIDTH = 16,
  parameter logic [HALF_WIDTH-1:0] MATCH_VAL = HALF_WIDTH'(1)
) (
  input  logic [2*HALF_WIDTH-1:0] data,
  output logic                    m
);
  logic [1:0] w_sum;
  // Only 2'b11 wraps to zero after the increment.
  assign w_sum = {data[2*HALF_WIDTH-1:HALF_WIDTH] == MATCH_VAL, data[HALF_WIDTH-1:0] == MATCH_VAL} + 2'd1;
  assign m = (w_sum == 2'd0);
endmodule

// File: rtl/half_match_frame_arbiter.sv
// half_match_frame_arbiter: round-robin frame arbiter counting fully matching words per frame.
module half_match_frame_arbiter
  import half_match_frame_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH/2-1:0] MATCH_VAL = (DATA_WIDTH/2)'(DEF_MATCH_VAL),
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_last,
  input  logic                  din0_vld,
  output logic                  din0_rd,
  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_last,
  input  logic                  din1_vld,
  output logic                  din1_rd,
  output logic                  dout_src,
  output logic [CNT_WIDTH-1:0]  dout_cnt,
  output logic                  dout_all,
  output logic                  dout_vld,
  input  logic                  dout_rd
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  state_t r_state, w_next;
  logic r_prio, r_src, r_all;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] w_data;
  logic w_any, w_grant, w_vld, w_last, w_acc, w_m;
  assign w_any = din0_vld | din1_vld;
  // Priority holder wins if valid, otherwise the other (necessarily valid) source.
  assign w_grant = r_prio ? din1_vld : !din0_vld;
  assign w_data = r_src ? din1_data : din0_data;
  assign w_vld = r_src ? din1_vld : din0_vld;
  assign w_last = r_src ? din1_last : din0_last;
  assign w_acc = (r_state == BUSY) && w_vld;
  assign dout_src = r_src;
  assign dout_cnt = r_cnt;
  assign dout_all = r_all;
  half_match_cmp #(.HALF_WIDTH(DATA_WIDTH/2), .MATCH_VAL(MATCH_VAL)) u_cmp (
    .data(w_data),
    .m(w_m)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    din0_rd = 1'b0;
    din1_rd = 1'b0;
    dout_vld = 1'b0;
    case (r_state)
      IDLE: w_next = w_any ? BUSY : IDLE;
      BUSY: begin
        din0_rd = !r_src;
        din1_rd = r_src;
        w_next = (w_acc && w_last) ? EMIT : BUSY;
      end
      EMIT: begin
        dout_vld = 1'b1;
        w_next = dout_rd ? IDLE : EMIT;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
      r_src <= 1'b0;
      r_cnt <= '0;
      r_all <= 1'b1;
    end else if (r_state == IDLE && w_any) begin
      r_src <= w_grant;
      r_cnt <= '0;
      r_all <= 1'b1;
    end else if (w_acc) begin
      r_cnt <= r_cnt + CNT_WIDTH'(w_m && (r_cnt != CNT_MAX));
      r_all <= r_all & w_m;
    end else if (r_state == EMIT && dout_rd) begin
      r_prio <= !r_src;
    end
  end
endmodule

// File: tb/tb_half_match_frame_arbiter.sv
// tb_half_match_frame_arbiter: randomized frame traffic checked against a frame-level round-robin model.
module tb_half_match_frame_arbiter;
  typedef struct {logic src; int cnt; logic all;} exp_t;
  typedef struct {int cnt; logic all;} res_t;
  logic clk, rst, dout_rd, dout_src, dout_all, dout_vld;
  logic [7:0] dout_cnt;
  logic [1:0][31:0] d_data;
  logic [1:0] d_last, d_vld, rd, prev_last;
  logic [31:0] qd[2][$];
  logic ql[2][$];
  res_t rq[2][$];
  exp_t exp_q[$];
  logic m_prio, gap_en, lr_src, lr_all;
  int lr_cnt, bp_mode, errors, checks;
  int xfer_cnt[2];
  half_match_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .din0_data(d_data[0]), .din0_last(d_last[0]), .din0_vld(d_vld[0]), .din0_rd(rd[0]),
    .din1_data(d_data[1]), .din1_last(d_last[1]), .din1_vld(d_vld[1]), .din1_rd(rd[1]),
    .dout_src(dout_src), .dout_cnt(dout_cnt), .dout_all(dout_all),
    .dout_vld(dout_vld), .dout_rd(dout_rd)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // Requester drivers: hold a presented word until taken; gaps only inside frames.
  initial begin
    logic [1:0] xf;
    d_vld = 0; d_last = 0; d_data = '0; prev_last = '1;
    forever begin
      @(negedge clk);
      xf = d_vld & rd;
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) begin
        if (xf[g] && qd[g].size() > 0) begin
          prev_last[g] = ql[g][0];
          void'(qd[g].pop_front());
          void'(ql[g].pop_front());
        end
        if (xf[g] || !d_vld[g] || qd[g].size() == 0)
          d_vld[g] = (qd[g].size() > 0) && (prev_last[g] || !gap_en || $urandom_range(0, 3) != 0);
        if (qd[g].size() > 0) begin
          d_data[g] = qd[g][0];
          d_last[g] = ql[g][0];
        end
      end
    end
  end
  initial begin
    dout_rd = 1;
    forever begin
      @(posedge clk); #1;
      dout_rd = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end
  // Scoreboard and protocol monitor.
  initial begin
    logic hold, pend;
    logic [10:0] snap;
    hold = 0; pend = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0; pend = 0;
      end else begin
        if (pend) begin
          checks++;
          if (dout_vld !== 1'b1) begin errors++; $display("FAIL latency: dout_vld=%b want 1 after last word", dout_vld); end
        end
        pend = |(d_vld & rd & d_last);
        if (hold) begin
          checks++;
          if ({dout_vld, dout_src, dout_cnt, dout_all} !== snap) begin
            errors++; $display("FAIL hold: dout=%h want %h", {dout_vld, dout_src, dout_cnt, dout_all}, snap);
          end
        end
        if (dout_vld) begin
          checks++;
          if (rd !== 2'b00) begin errors++; $display("FAIL rd_in_emit: rd=%b want 00", rd); end
        end
        if (rd != 2'b00 && exp_q.size() > 0) begin
          checks++;
          if (rd[!exp_q[0].src] !== 1'b0) begin
            errors++; $display("FAIL grant: rd=%b while frame of src %0d pending", rd, exp_q[0].src);
          end
        end
        for (int g = 0; g < 2; g++) if (d_vld[g] & rd[g]) xfer_cnt[g]++;
        if (dout_vld & dout_rd) begin
          lr_src = dout_src; lr_cnt = dout_cnt; lr_all = dout_all;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL result: unexpected src=%0d cnt=%0d all=%0d", dout_src, dout_cnt, dout_all);
          end else begin
            if (dout_src !== exp_q[0].src || int'(dout_cnt) != exp_q[0].cnt || dout_all !== exp_q[0].all) begin
              errors++;
              $display("FAIL result: src=%0d cnt=%0d all=%0d want src=%0d cnt=%0d all=%0d",
                       dout_src, dout_cnt, dout_all, exp_q[0].src, exp_q[0].cnt, exp_q[0].all);
            end
            void'(exp_q.pop_front());
          end
        end
        hold = dout_vld & !dout_rd;
        snap = {dout_vld, dout_src, dout_cnt, dout_all};
      end
    end
  end
  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0, 1: return 32'h0001_0001;
      2: return {16'h0001, 16'($urandom_range(0, 2))};
      3: return {16'($urandom_range(0, 2)), 16'h0001};
      default: return $urandom;
    endcase
  endfunction
  task automatic add_frame(input int s, input logic [31:0] w[$]);
    int n = 0;
    foreach (w[i]) begin
      qd[s].push_back(w[i]);
      ql[s].push_back(i == w.size() - 1);
      if (w[i] == 32'h0001_0001) n++;
    end
    rq[s].push_back('{cnt: (n > 255) ? 255 : n, all: n == w.size()});
  endtask
  // Frame-level round robin: priority source if it has a frame, else the other.
  task automatic schedule();
    logic s;
    while (rq[0].size() > 0 || rq[1].size() > 0) begin
      s = (rq[m_prio].size() > 0) ? m_prio : !m_prio;
      exp_q.push_back('{src: s, cnt: rq[s][0].cnt, all: rq[s][0].all});
      void'(rq[s].pop_front());
      m_prio = !s;
    end
  endtask
  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || qd[0].size() > 0 || qd[1].size() > 0) && c < budget) begin
      @(negedge clk); c++;
    end
    if (c >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d results outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    rst = 1; gap_en = 0; bp_mode = 0; m_prio = 0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (rd[0] !== 0) begin errors++; $display("FAIL reset_rd0: %b want 0", rd[0]); end
    if (rd[1] !== 0) begin errors++; $display("FAIL reset_rd1: %b want 0", rd[1]); end
    if (dout_vld !== 0) begin errors++; $display("FAIL reset_vld: %b want 0", dout_vld); end
    if (dout_src !== 0) begin errors++; $display("FAIL reset_src: %b want 0", dout_src); end
    if (dout_cnt !== 0) begin errors++; $display("FAIL reset_cnt: %0d want 0", dout_cnt); end
    if (dout_all !== 1) begin errors++; $display("FAIL reset_all: %b want 1", dout_all); end
    rst = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    add_frame(0, '{32'h0001_0001, 32'h0001_0002, 32'h0001_0001});
    schedule();
    wait_done("basic", 50);
    checks += 3;
    if (lr_src !== 0) begin errors++; $display("FAIL basic_src: %0d want 0", lr_src); end
    if (lr_cnt != 2) begin errors++; $display("FAIL basic_cnt: %0d want 2", lr_cnt); end
    if (lr_all !== 0) begin errors++; $display("FAIL basic_all: %0d want 0", lr_all); end
  endtask
  task automatic test_saturate();
    logic [31:0] w[$];
    repeat (300) w.push_back(32'h0001_0001);
    add_frame(1, w);
    schedule();
    wait_done("saturate", 500);
    checks += 3;
    if (lr_src !== 1) begin errors++; $display("FAIL sat_src: %0d want 1", lr_src); end
    if (lr_cnt != 255) begin errors++; $display("FAIL sat_cnt: %0d want 255", lr_cnt); end
    if (lr_all !== 1) begin errors++; $display("FAIL sat_all: %0d want 1", lr_all); end
  endtask
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      add_frame(0, '{32'h0001_0001, 32'h0001_0001});
      add_frame(1, '{32'h0001_0001, 32'h0001_0001});
    end
    schedule();
    wait_done("alternate", 200);
  endtask
  task automatic test_backpressure();
    int c = 0;
    bp_mode = 2;
    @(posedge clk); #2;
    add_frame(0, '{32'h0001_0001, 32'h0000_0001});
    add_frame(1, '{32'h0001_0001});
    schedule();
    while (!dout_vld && c < 50) begin @(negedge clk); c++; end
    for (int i = 0; i < 5; i++) begin
      checks += 2;
      if (dout_vld !== 1) begin errors++; $display("FAIL bp_vld: %b want 1 (cycle %0d)", dout_vld, i); end
      if (rd !== 2'b00) begin errors++; $display("FAIL bp_rd: %b want 00 (cycle %0d)", rd, i); end
      @(negedge clk);
    end
    bp_mode = 0;
    wait_done("backpressure", 100);
  endtask
  task automatic test_random();
    logic [31:0] w[$];
    gap_en = 1; bp_mode = 1;
    for (int f = 0; f < 10; f++)
      for (int s = 0; s < 2; s++) begin
        w.delete();
        repeat ($urandom_range(1, 6)) w.push_back(rand_word());
        if ($urandom_range(0, 3) != 0) add_frame(s, w);
      end
    schedule();
    wait_done("random", 2000);
    gap_en = 0; bp_mode = 0;
  endtask
  task automatic test_reset_mid();
    int c = 0;
    int base = xfer_cnt[0];
    add_frame(0, '{32'h0001_0001, 32'h0001_0001, 32'h0001_0001, 32'h0001_0001});
    schedule();
    while (xfer_cnt[0] < base + 2 && c < 50) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    rst = 1;
    for (int g = 0; g < 2; g++) begin qd[g].delete(); ql[g].delete(); rq[g].delete(); end
    exp_q.delete();
    m_prio = 0; prev_last = '1;
    #1;
    checks += 5;
    if (dout_vld !== 0) begin errors++; $display("FAIL rstmid_vld: %b want 0", dout_vld); end
    if (rd !== 2'b00) begin errors++; $display("FAIL rstmid_rd: %b want 00", rd); end
    if (dout_src !== 0) begin errors++; $display("FAIL rstmid_src: %b want 0", dout_src); end
    if (dout_cnt !== 0) begin errors++; $display("FAIL rstmid_cnt: %0d want 0", dout_cnt); end
    if (dout_all !== 1) begin errors++; $display("FAIL rstmid_all: %b want 1", dout_all); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    add_frame(1, '{32'h0001_0001, 32'h0002_0001, 32'h0001_0001});
    add_frame(0, '{32'h0001_0001});
    schedule();
    wait_done("rstmid", 100);
  endtask
  initial begin
    errors = 0; checks = 0; xfer_cnt = '{0, 0};
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
